arbitro_escritura: RTL and testbench

ARBITRO_ESCRITURA -- requirements
Module: arbitro_escritura

---
 rtl/arbitro_escritura_pkg.sv | 11 +
 rtl/fifo_escritura.sv | 43 ++++
 rtl/arbitro_escritura.sv | 73 +++++++
 tb/tb_arbitro_escritura.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_escritura_pkg.sv
// arbitro_escritura_pkg: shared defaults and types for the write-back arbiter
package arbitro_escritura_pkg;
    localparam int N = 32;
    localparam int Bits = 64;
    localparam int WB_DEPTH = 4;
    typedef struct packed {
        logic [$clog2(N)-1:0] rd;
        logic [Bits-1:0]      data;
    } wb_entry_t;
    typedef enum logic {SRC_MEM, SRC_ALU} wb_src_t;
endpackage

// File: rtl/fifo_escritura.sv
// fifo_escritura: Depth-entry write-back FIFO with occupancy count
module fifo_escritura
    import arbitro_escritura_pkg::*;
#(
    parameter int Depth = WB_DEPTH,
    parameter type T = wb_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  T                         din,
    output T                         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);
    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;
    T mem [Depth];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign full = count == CW'(Depth);
    assign empty = count == '0;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    // pointers wrap naturally because Depth is a power of two
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/arbitro_escritura.sv
// arbitro_escritura: merges ALU and load results into one register-bank write port
module arbitro_escritura #(
    parameter int N = 32,
    parameter int Bits = 64,
    parameter int Depth = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [$clog2(N)-1:0]  alu_rd,
    input  logic [Bits-1:0]       alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [$clog2(N)-1:0]  mem_rd,
    input  logic [Bits-1:0]       mem_data,
    output logic                  wr_en,
    output logic [$clog2(N)-1:0]  ptr_wr,
    output logic [Bits-1:0]       data_wr,
    output logic                  busy
);
    import arbitro_escritura_pkg::*;
    localparam int PW = $clog2(N);
    typedef struct packed {
        logic [PW-1:0]   rd;
        logic [Bits-1:0] data;
    } entry_t;
    entry_t alu_in, mem_in, alu_head, mem_head, sel;
    logic alu_full, alu_empty, mem_full, mem_empty, pop_alu, pop_mem, do_write;
    logic [$clog2(Depth):0] alu_count, mem_count;
    wb_src_t prio_q, prio_d;
    assign alu_in = '{rd: alu_rd, data: alu_data};
    assign mem_in = '{rd: mem_rd, data: mem_data};
    assign alu_ready = rst && !alu_full;
    assign mem_ready = rst && !mem_full;
    assign busy = |{alu_count, mem_count};
    fifo_escritura #(.Depth(Depth), .T(entry_t)) u_fifo_alu (
        .clk(clk), .rst(rst), .push(alu_valid && alu_ready), .pop(pop_alu),
        .din(alu_in), .dout(alu_head), .full(alu_full), .empty(alu_empty), .count(alu_count)
    );
    fifo_escritura #(.Depth(Depth), .T(entry_t)) u_fifo_mem (
        .clk(clk), .rst(rst), .push(mem_valid && mem_ready), .pop(pop_mem),
        .din(mem_in), .dout(mem_head), .full(mem_full), .empty(mem_empty), .count(mem_count)
    );
    // prio_q names the source that wins the next tie
    always_ff @(posedge clk) begin
        if (!rst) prio_q <= SRC_MEM;
        else prio_q <= prio_d;
    end
    always_comb begin
        prio_d = pop_alu ? SRC_MEM : pop_mem ? SRC_ALU : prio_q;
    end
    always_comb begin
        pop_alu = !alu_empty && (mem_empty || prio_q == SRC_ALU);
        pop_mem = !mem_empty && !pop_alu;
        sel = pop_alu ? alu_head : mem_head;
        do_write = (pop_alu || pop_mem) && sel.rd != '0;
    end
    // x0 entries are drained silently so ptr_wr/data_wr keep the last real write
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_en <= 1'b0;
            ptr_wr <= '0;
            data_wr <= '0;
        end else begin
            wr_en <= do_write;
            if (do_write) begin
                ptr_wr <= sel.rd;
                data_wr <= sel.data;
            end
        end
    end
endmodule

// File: tb/tb_arbitro_escritura.sv
// tb_arbitro_escritura: queue-model scoreboard plus directed write-back scenarios
module tb_arbitro_escritura;
    localparam int N = 32;
    localparam int Bits = 64;
    localparam int Depth = 4;
    logic clk = 0, rst = 0;
    logic alu_valid = 0, mem_valid = 0, alu_ready, mem_ready, wr_en, busy;
    logic [4:0] alu_rd = 0, mem_rd = 0, ptr_wr;
    logic [63:0] alu_data = 0, mem_data = 0, data_wr;
    int checks = 0, errors = 0, nwr = 0, n0, ai, mk, k, j;
    bit saw_full;
    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;
    ent_t aq[$], mq[$], wlog[$];
    logic m_wr = 0;
    logic [4:0] m_ptr = 0;
    logic [63:0] m_data = 0;
    bit alu_turn = 0;

    arbitro_escritura #(.N(N), .Bits(Bits), .Depth(Depth)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .wr_en(wr_en), .ptr_wr(ptr_wr), .data_wr(data_wr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: two queues, one pop per edge, ties alternate starting with MEM
    always @(posedge clk) begin
        int na, nm;
        ent_t e;
        bit got;
        na = aq.size();
        nm = mq.size();
        got = 0;
        if (!rst) begin
            aq.delete();
            mq.delete();
            alu_turn = 0;
            m_wr = 0;
            m_ptr = 0;
            m_data = 0;
        end else begin
            if (na > 0 && (nm == 0 || alu_turn)) begin
                e = aq.pop_front();
                alu_turn = 0;
                got = 1;
            end else if (nm > 0) begin
                e = mq.pop_front();
                alu_turn = 1;
                got = 1;
            end
            m_wr = got && e.rd != 0;
            if (m_wr) begin
                m_ptr = e.rd;
                m_data = e.data;
            end
            if (alu_valid && na < Depth) aq.push_back('{alu_rd, alu_data});
            if (mem_valid && nm < Depth) mq.push_back('{mem_rd, mem_data});
        end
    end

    always @(posedge clk) begin
        #1;
        chk("wr_en", 64'(wr_en), 64'(m_wr));
        chk("ptr_wr", 64'(ptr_wr), 64'(m_ptr));
        chk("data_wr", data_wr, m_data);
        chk("busy", 64'(busy), 64'(aq.size() + mq.size() > 0));
        chk("alu_ready", 64'(alu_ready), 64'(rst && aq.size() < Depth));
        chk("mem_ready", 64'(mem_ready), 64'(rst && mq.size() < Depth));
        if (wr_en === 1'b1) begin
            nwr++;
            wlog.push_back('{ptr_wr, data_wr});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_wr_en", 64'(wr_en), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_ready", 64'({alu_ready, mem_ready}), 64'(0));
        chk("reset_ptr_data", 64'(ptr_wr) | data_wr, 64'(0));
        rst = 1;
        @(negedge clk);
        chk("ready_after_release", 64'({alu_ready, mem_ready}), 64'(3));

        // single write
        n0 = nwr;
        alu_valid = 1; alu_rd = 5; alu_data = 64'hDEAD_BEEF;
        @(negedge clk);
        chk("single_accepted_busy", 64'(busy), 64'(1));
        chk("single_no_early_wr", 64'(wr_en), 64'(0));
        alu_valid = 0;
        @(negedge clk);
        chk("single_wr_en", 64'(wr_en), 64'(1));
        chk("single_ptr", 64'(ptr_wr), 64'(5));
        chk("single_data", data_wr, 64'hDEAD_BEEF);
        repeat (4) @(negedge clk);
        chk("single_strobes", 64'(nwr - n0), 64'(1));

        // ties: reset first so the first tie is the first after reset
        rst = 0;
        @(negedge clk);
        rst = 1;
        mem_valid = 1; mem_rd = 3; mem_data = 64'h33;
        alu_valid = 1; alu_rd = 7; alu_data = 64'h77;
        @(negedge clk);
        mem_rd = 4; mem_data = 64'h44;
        alu_rd = 8; alu_data = 64'h88;
        @(negedge clk);
        mem_valid = 0; alu_valid = 0;
        chk("tie1_mem_first", 64'(ptr_wr), 64'(3));
        @(negedge clk);
        chk("tie1_alu_next", 64'(ptr_wr), 64'(7));
        @(negedge clk);
        chk("tie2_after_alu_goes_mem", 64'(ptr_wr), 64'(4));
        @(negedge clk);
        chk("tie2_last_alu", 64'(ptr_wr), 64'(8));
        chk("tie2_last_data", data_wr, 64'h88);

        // x0 is consumed without a strobe
        n0 = nwr;
        alu_valid = 1; alu_rd = 0; alu_data = 64'hFFFF;
        @(negedge clk);
        alu_valid = 0;
        chk("x0_queued", 64'(busy), 64'(1));
        @(negedge clk);
        chk("x0_busy_falls", 64'(busy), 64'(0));
        chk("x0_no_wr", 64'(wr_en), 64'(0));
        chk("x0_ptr_hold", 64'(ptr_wr), 64'(8));
        chk("x0_data_hold", data_wr, 64'h88);
        repeat (2) @(negedge clk);
        chk("x0_strobes", 64'(nwr - n0), 64'(0));

        // full and wrap: MEM competes for the port while ALU streams 10 entries
        wlog.delete();
        ai = 0; mk = 0; saw_full = 0;
        for (int c = 0; c < 200 && ai < 10; c++) begin
            @(negedge clk);
            alu_valid = 1; alu_rd = 5'(ai + 1); alu_data = 64'hA000 + 64'(ai);
            mem_valid = mk < 12; mem_rd = 5'(16 + mk); mem_data = 64'hB000 + 64'(mk);
            if (alu_ready) ai++;
            else saw_full = 1;
            if (mem_valid && mem_ready) mk++;
        end
        @(negedge clk);
        alu_valid = 0; mem_valid = 0;
        chk("wrap_saw_alu_full", 64'(saw_full), 64'(1));
        for (int c = 0; c < 60 && busy; c++) @(negedge clk);
        chk("wrap_drained", 64'(busy), 64'(0));
        k = 0; j = 0;
        foreach (wlog[i]) begin
            if (wlog[i].data[15:12] == 4'hA) begin
                chk("wrap_alu_rd", 64'(wlog[i].rd), 64'(k + 1));
                chk("wrap_alu_data", wlog[i].data, 64'hA000 + 64'(k));
                k++;
            end else begin
                chk("wrap_mem_rd", 64'(wlog[i].rd), 64'(16 + j));
                j++;
            end
        end
        chk("wrap_alu_count", 64'(k), 64'(10));
        chk("wrap_mem_count", 64'(j), 64'(mk));

        // reset with three entries queued
        @(negedge clk);
        alu_valid = 1; alu_rd = 9; alu_data = 64'hC0;
        mem_valid = 1; mem_rd = 10; mem_data = 64'hC1;
        @(negedge clk);
        alu_rd = 11; alu_data = 64'hC2;
        mem_rd = 12; mem_data = 64'hC3;
        @(negedge clk);
        alu_valid = 0; mem_valid = 0;
        chk("midrst_busy_before", 64'(busy), 64'(1));
        rst = 0;
        n0 = nwr;
        @(negedge clk);
        chk("midrst_wr_en", 64'(wr_en), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_ready", 64'({alu_ready, mem_ready}), 64'(0));
        rst = 1;
        repeat (5) @(negedge clk);
        chk("midrst_ready_after", 64'({alu_ready, mem_ready}), 64'(3));
        chk("midrst_no_stale", 64'(nwr - n0), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
